hazard_stall_ctrl: RTL and testbench
====================================

Name: hazard_stall_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage RV32 core; companion to the forwarding logic: it handles the hazards that forwarding cannot resolve.
- Generates per-stage register enables and flushes for load-use bubbles, branch/jump redirect flushes, and instruction/data memory wait freezes.
- Adds a post-reset boot sequence and a freeze watchdog.
- Sits beside the ID/EXE pipeline registers; all outputs drive the PC, IF/ID, ID/EXE, EXE/MEM and MEM/WB registers directly.

Parameters:
- BOOT_CYCLES, 4, cycles after reset release during which the pipeline is held flushed and the PC is frozen (1..15).
- LOAD_BUBBLES, 1, bubbles inserted per load-use hazard (1..3).
- WD_LIMIT, 255, consecutive freeze cycles after which wd_timeout sets (1..65535).

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- ID_rs1_addr  in  5  rs1 of instruction in ID
- ID_rs2_addr  in  5  rs2 of instruction in ID
- ID_rs1_used  in  1  ID instruction reads rs1
- ID_rs2_used  in  1  ID instruction reads rs2
- EXE_memRead  in  1  instruction in EXE is a load
- EXE_rd_addr  in  5  rd of instruction in EXE
- EXE_branch_taken  in  1  branch taken or jump resolved in EXE
- IM_stall  in  1  instruction memory not ready
- DM_stall  in  1  data memory not ready
- pc_en  out  1  PC register load enable
- ifid_en  out  1  IF/ID register enable
- ifid_flush  out  1  IF/ID clear to NOP (applies only when ifid_en=1)
- idexe_flush  out  1  ID/EXE loads NOP
- pipe_en  out  1  ID/EXE, EXE/MEM and MEM/WB enable
- wd_timeout  out  1  sticky: freeze exceeded WD_LIMIT
- ctrl_state  out  2  current FSM state, for debug

Behaviour:
- Reset values while rst_n=0: state=BOOT, boot counter=BOOT_CYCLES-1, bubble counter=0, wd counter=0, wd_timeout=0.
- Outputs during reset equal the BOOT outputs: pc_en=0, ifid_en=1, ifid_flush=1, idexe_flush=1, pipe_en=1.
- States and encoding: BOOT=0, RUN=1, BUBBLE=2, FREEZE=3. Outputs are combinational from state, counters and inputs; all state updates happen on the rising edge of clk.
- A hazard (hz) is: EXE_memRead && EXE_rd_addr!=0 && ((ID_rs1_used && ID_rs1_addr==EXE_rd_addr) || (ID_rs2_used && ID_rs2_addr==EXE_rd_addr)).
- Freeze (frz) is IM_stall || DM_stall.
- BOOT:
  - Outputs as at reset.
  - The counter decrements each cycle. When it reaches 0, the next state is RUN.
  - frz is ignored in BOOT.
- RUN, evaluated in priority order:
  - frz: all enables 0, all flushes 0. Next state FREEZE.
  - EXE_branch_taken: pc_en=1, ifid_en=1, ifid_flush=1, idexe_flush=1, pipe_en=1. Stay in RUN. Branch takes priority over hz because a wrong-path load-use is discarded.
  - hz: pc_en=0, ifid_en=0, idexe_flush=1, pipe_en=1. If LOAD_BUBBLES>1, load the bubble counter with LOAD_BUBBLES-2 and go to BUBBLE; otherwise stay in RUN.
  - Otherwise: all enables 1, all flushes 0.
- BUBBLE:
  - Same outputs as hz in RUN.
  - The counter decrements each cycle; when it is 0, return to RUN.
  - frz takes priority: all enables 0, the counter holds, and the state stays BUBBLE. The bubble resumes when the freeze releases.
- FREEZE:
  - All enables 0, all flushes 0.
  - Stay while frz=1. Return to RUN on the first cycle with frz=0; RUN then re-evaluates branch and hz in that cycle.
- Watchdog:
  - The wd counter increments on every cycle with frz=1 in RUN, BUBBLE or FREEZE, and clears on any cycle with frz=0.
  - When the counter reaches WD_LIMIT, wd_timeout sets and stays set until reset. The counter saturates.
- Reset mid-operation: asynchronous return to the reset values; any in-progress bubble or freeze is abandoned.
- Register x0 never creates a hazard.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- When defined, three 32-bit wrapping counters are added and exposed as outputs perf_bubble_cnt, perf_flush_cnt and perf_freeze_cnt:
  - perf_bubble_cnt counts cycles with idexe_flush=1 && pc_en=0.
  - perf_flush_cnt counts branch-flush cycles.
  - perf_freeze_cnt counts cycles with frz=1.
  - All three reset to 0 and do not count in BOOT.
- When undefined, the counters and their ports do not exist. Behaviour is otherwise identical.

Test Plan:
- Reset, BOOT_CYCLES=4, no stalls: pc_en=0 and both flushes=1 for exactly 4 cycles after rst_n rises; pc_en=1 on cycle 5; ctrl_state goes 0 then 1.
- RUN, EXE_memRead=1, EXE_rd_addr=5, ID_rs1_addr=5, ID_rs1_used=1: exactly one cycle of pc_en=0, ifid_en=0, idexe_flush=1. With LOAD_BUBBLES=3 this lasts three cycles. With EXE_rd_addr=0 there is no stall.
- Hazard and EXE_branch_taken=1 in the same cycle: ifid_flush=1, idexe_flush=1, pc_en=1, and no bubble follows.
- DM_stall=1 for 10 cycles in the middle of a LOAD_BUBBLES=3 bubble after the first bubble cycle: all enables 0 for 10 cycles, then the 2 remaining bubble cycles, then RUN.
- WD_LIMIT=8, IM_stall held for 9 cycles: wd_timeout rises after the 8th freeze cycle and stays 1 after the stall drops; it clears only when rst_n is asserted.
- With HAZARD_PERF_CNT_EN: 3 load-use hazards, 2 taken branches and 5 freeze cycles give counts 3, 2 and 5; asserting rst_n mid-sequence zeroes all three.

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: stall/flush sequencing for the 5-stage RV32 pipeline (load-use bubbles, redirects, memory waits, boot hold, freeze watchdog).
// Optional feature macro HAZARD_PERF_CNT_EN adds bubble/flush/freeze performance counters.
module hazard_stall_ctrl #(
   parameter int BOOT_CYCLES  = 4,
   parameter int LOAD_BUBBLES = 1,
   parameter int WD_LIMIT     = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [4:0]  ID_rs1_addr,
   input  logic [4:0]  ID_rs2_addr,
   input  logic        ID_rs1_used,
   input  logic        ID_rs2_used,
   input  logic        EXE_memRead,
   input  logic [4:0]  EXE_rd_addr,
   input  logic        EXE_branch_taken,
   input  logic        IM_stall,
   input  logic        DM_stall,
   output logic        pc_en,
   output logic        ifid_en,
   output logic        ifid_flush,
   output logic        idexe_flush,
   output logic        pipe_en,
   output logic        wd_timeout,
   output logic [1:0]  ctrl_state
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [31:0] perf_bubble_cnt,
   output logic [31:0] perf_flush_cnt,
   output logic [31:0] perf_freeze_cnt
`endif
);

   typedef enum logic [1:0] {
      ST_BOOT   = 2'd0,
      ST_RUN    = 2'd1,
      ST_BUBBLE = 2'd2,
      ST_FREEZE = 2'd3
   } state_t;

   localparam logic [3:0]  BOOT_INIT = 4'(BOOT_CYCLES - 1);
   localparam logic [1:0]  BUB_INIT  = (LOAD_BUBBLES > 1) ? 2'(LOAD_BUBBLES - 2) : 2'd0;
   localparam logic [15:0] WD_MAX    = 16'(WD_LIMIT);

   state_t      state_q, state_d;
   logic [3:0]  boot_cnt_q, boot_cnt_d;
   logic [1:0]  bub_cnt_q, bub_cnt_d;
   logic [15:0] wd_cnt_q;
   logic        wd_timeout_q;
   logic        hz;
   logic        frz;

   // x0 is hardwired to zero, so a load targeting it never blocks a consumer.
   assign hz = EXE_memRead && (EXE_rd_addr != 5'd0) &&
               ((ID_rs1_used && (ID_rs1_addr == EXE_rd_addr)) ||
                (ID_rs2_used && (ID_rs2_addr == EXE_rd_addr)));
   assign frz = IM_stall || DM_stall;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_BOOT;
         boot_cnt_q <= BOOT_INIT;
         bub_cnt_q  <= 2'd0;
      end else begin
         state_q    <= state_d;
         boot_cnt_q <= boot_cnt_d;
         bub_cnt_q  <= bub_cnt_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      boot_cnt_d  = boot_cnt_q;
      bub_cnt_d   = bub_cnt_q;
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      ifid_flush  = 1'b0;
      idexe_flush = 1'b0;
      pipe_en     = 1'b0;
      case (state_q)
         ST_BOOT: begin
            ifid_en     = 1'b1;
            ifid_flush  = 1'b1;
            idexe_flush = 1'b1;
            pipe_en     = 1'b1;
            if (boot_cnt_q == 4'd0) state_d = ST_RUN;
            else                    boot_cnt_d = boot_cnt_q - 4'd1;
         end
         ST_BUBBLE: begin
            // A freeze parks the bubble with its remaining count intact.
            if (!frz) begin
               idexe_flush = 1'b1;
               pipe_en     = 1'b1;
               if (bub_cnt_q == 2'd0) state_d = ST_RUN;
               else                   bub_cnt_d = bub_cnt_q - 2'd1;
            end
         end
         default: begin
            // FREEZE shares RUN's decode so the release cycle is not lost.
            if (frz) begin
               state_d = ST_FREEZE;
            end else begin
               state_d = ST_RUN;
               if (EXE_branch_taken) begin
                  pc_en       = 1'b1;
                  ifid_en     = 1'b1;
                  ifid_flush  = 1'b1;
                  idexe_flush = 1'b1;
                  pipe_en     = 1'b1;
               end else if (hz) begin
                  idexe_flush = 1'b1;
                  pipe_en     = 1'b1;
                  if (LOAD_BUBBLES > 1) begin
                     state_d   = ST_BUBBLE;
                     bub_cnt_d = BUB_INIT;
                  end
               end else begin
                  pc_en   = 1'b1;
                  ifid_en = 1'b1;
                  pipe_en = 1'b1;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wd_cnt_q     <= 16'd0;
         wd_timeout_q <= 1'b0;
      end else if (!frz) begin
         wd_cnt_q <= 16'd0;
      end else if (state_q != ST_BOOT) begin
         if (wd_cnt_q != WD_MAX) wd_cnt_q <= wd_cnt_q + 16'd1;
         if (wd_cnt_q >= WD_MAX - 16'd1) wd_timeout_q <= 1'b1;
      end
   end

   assign wd_timeout = wd_timeout_q;
   assign ctrl_state = state_q;

`ifdef HAZARD_PERF_CNT_EN
   // A branch flush is the only case with ifid_flush set while the PC advances.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_bubble_cnt <= 32'd0;
         perf_flush_cnt  <= 32'd0;
         perf_freeze_cnt <= 32'd0;
      end else if (state_q != ST_BOOT) begin
         if (idexe_flush && !pc_en) perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
         if (ifid_flush && pc_en)   perf_flush_cnt  <= perf_flush_cnt + 32'd1;
         if (frz)                   perf_freeze_cnt <= perf_freeze_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: directed bench driving two hazard_stall_ctrl instances (LOAD_BUBBLES 1 and 3) against a cycle model.
// Define HAZARD_PERF_CNT_EN to also check the performance counters.
module tb_hazard_stall_ctrl;

   localparam int NI = 2;

   logic       clk;
   logic       rst_n;
   logic [4:0] ID_rs1_addr, ID_rs2_addr, EXE_rd_addr;
   logic       ID_rs1_used, ID_rs2_used, EXE_memRead, EXE_branch_taken;
   logic       IM_stall, DM_stall;

   logic [NI-1:0] pc_en_v, ifid_en_v, ifid_flush_v, idexe_flush_v, pipe_en_v, wd_v;
   logic [1:0]    st_v [NI];
`ifdef HAZARD_PERF_CNT_EN
   logic [31:0]   pb_v [NI];
   logic [31:0]   pf_v [NI];
   logic [31:0]   pz_v [NI];
`endif

   int n_checks = 0;
   int n_errors = 0;
   bit cmp_on   = 1'b0;

   // ---------------- clock ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   hazard_stall_ctrl #(.BOOT_CYCLES(4), .LOAD_BUBBLES(1), .WD_LIMIT(8)) dut_a (
      .clk(clk), .rst_n(rst_n),
      .ID_rs1_addr(ID_rs1_addr), .ID_rs2_addr(ID_rs2_addr),
      .ID_rs1_used(ID_rs1_used), .ID_rs2_used(ID_rs2_used),
      .EXE_memRead(EXE_memRead), .EXE_rd_addr(EXE_rd_addr),
      .EXE_branch_taken(EXE_branch_taken), .IM_stall(IM_stall), .DM_stall(DM_stall),
      .pc_en(pc_en_v[0]), .ifid_en(ifid_en_v[0]), .ifid_flush(ifid_flush_v[0]),
      .idexe_flush(idexe_flush_v[0]), .pipe_en(pipe_en_v[0]), .wd_timeout(wd_v[0]),
      .ctrl_state(st_v[0])
`ifdef HAZARD_PERF_CNT_EN
      , .perf_bubble_cnt(pb_v[0]), .perf_flush_cnt(pf_v[0]), .perf_freeze_cnt(pz_v[0])
`endif
   );

   hazard_stall_ctrl #(.BOOT_CYCLES(4), .LOAD_BUBBLES(3), .WD_LIMIT(12)) dut_b (
      .clk(clk), .rst_n(rst_n),
      .ID_rs1_addr(ID_rs1_addr), .ID_rs2_addr(ID_rs2_addr),
      .ID_rs1_used(ID_rs1_used), .ID_rs2_used(ID_rs2_used),
      .EXE_memRead(EXE_memRead), .EXE_rd_addr(EXE_rd_addr),
      .EXE_branch_taken(EXE_branch_taken), .IM_stall(IM_stall), .DM_stall(DM_stall),
      .pc_en(pc_en_v[1]), .ifid_en(ifid_en_v[1]), .ifid_flush(ifid_flush_v[1]),
      .idexe_flush(idexe_flush_v[1]), .pipe_en(pipe_en_v[1]), .wd_timeout(wd_v[1]),
      .ctrl_state(st_v[1])
`ifdef HAZARD_PERF_CNT_EN
      , .perf_bubble_cnt(pb_v[1]), .perf_flush_cnt(pf_v[1]), .perf_freeze_cnt(pz_v[1])
`endif
   );

   // ---------------- scoreboard helpers ----------------
   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   function automatic int lb_of(int i);
      return (i == 0) ? 1 : 3;
   endfunction

   function automatic int wd_of(int i);
      return (i == 0) ? 8 : 12;
   endfunction

   int boot_left [NI];   // boot cycles still to run
   int bub_left  [NI];   // bubble cycles still owed after the hazard cycle
   int frz_run   [NI];   // consecutive non-boot freeze cycles
   bit prev_frz  [NI];
   bit wd_flag   [NI];
   int exp_pb    [NI];
   int exp_pf    [NI];
   int exp_pz    [NI];

   function automatic bit hz_in();
      bit hit = 1'b0;
      if (EXE_memRead && EXE_rd_addr != 5'd0) begin
         if (ID_rs1_used && ID_rs1_addr == EXE_rd_addr) hit = 1'b1;
         if (ID_rs2_used && ID_rs2_addr == EXE_rd_addr) hit = 1'b1;
      end
      return hit;
   endfunction

   function automatic bit frz_in();
      return IM_stall || DM_stall;
   endfunction

   // {pc_en, ifid_en, ifid_flush, idexe_flush, pipe_en, wd_timeout, ctrl_state[1:0]}
   function automatic logic [7:0] expect_out(int i);
      logic [4:0] o;
      logic [1:0] s;
      if (boot_left[i] > 0) begin
         o = 5'b01111;
         s = 2'd0;
      end else begin
         if (bub_left[i] > 0)  s = 2'd2;
         else if (prev_frz[i]) s = 2'd3;
         else                  s = 2'd1;
         if (frz_in())                                         o = 5'b00000;
         else if (bub_left[i] > 0)                             o = 5'b00011;
         else if (EXE_branch_taken)                            o = 5'b11111;
         else if (hz_in())                                     o = 5'b00011;
         else                                                  o = 5'b11001;
      end
      return {o, wd_flag[i], s};
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NI; i++) begin
            boot_left[i] <= 4;
            bub_left[i]  <= 0;
            frz_run[i]   <= 0;
            prev_frz[i]  <= 1'b0;
            wd_flag[i]   <= 1'b0;
            exp_pb[i]    <= 0;
            exp_pf[i]    <= 0;
            exp_pz[i]    <= 0;
         end
      end else begin
         for (int i = 0; i < NI; i++) begin
            logic [7:0] e;
            e = expect_out(i);
            if (!frz_in()) frz_run[i] <= 0;
            if (boot_left[i] > 0) begin
               boot_left[i] <= boot_left[i] - 1;
               prev_frz[i]  <= 1'b0;
            end else begin
               prev_frz[i] <= frz_in();
               if (e[7:3] == 5'b00011) exp_pb[i] <= exp_pb[i] + 1;
               if (e[7:3] == 5'b11111) exp_pf[i] <= exp_pf[i] + 1;
               if (frz_in()) begin
                  exp_pz[i] <= exp_pz[i] + 1;
                  if (frz_run[i] < wd_of(i)) frz_run[i] <= frz_run[i] + 1;
                  if (frz_run[i] + 1 >= wd_of(i)) wd_flag[i] <= 1'b1;
               end else if (bub_left[i] > 0) begin
                  bub_left[i] <= bub_left[i] - 1;
               end else if (!EXE_branch_taken && hz_in()) begin
                  bub_left[i] <= lb_of(i) - 1;
               end
            end
         end
      end
   end

   // compare every cycle, away from the active edge
   always @(negedge clk) begin
      if (cmp_on) begin
         for (int i = 0; i < NI; i++) begin
            logic [7:0] got;
            got = {pc_en_v[i], ifid_en_v[i], ifid_flush_v[i], idexe_flush_v[i],
                   pipe_en_v[i], wd_v[i], st_v[i]};
            chk($sformatf("model_out[%0d]", i), 32'(got), 32'(expect_out(i)));
`ifdef HAZARD_PERF_CNT_EN
            chk($sformatf("model_perf_bubble[%0d]", i), pb_v[i], 32'(exp_pb[i]));
            chk($sformatf("model_perf_flush[%0d]", i),  pf_v[i], 32'(exp_pf[i]));
            chk($sformatf("model_perf_freeze[%0d]", i), pz_v[i], 32'(exp_pz[i]));
`endif
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic quiet();
      ID_rs1_addr = 5'd0; ID_rs2_addr = 5'd0; EXE_rd_addr = 5'd0;
      ID_rs1_used = 1'b0; ID_rs2_used = 1'b0; EXE_memRead = 1'b0;
      EXE_branch_taken = 1'b0; IM_stall = 1'b0; DM_stall = 1'b0;
   endtask

   task automatic apply(input logic mr, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic u1, input logic [4:0] rs2, input logic u2,
                        input logic br, input logic im, input logic dm, input int idle);
      EXE_memRead = mr; EXE_rd_addr = rd;
      ID_rs1_addr = rs1; ID_rs1_used = u1; ID_rs2_addr = rs2; ID_rs2_used = u2;
      EXE_branch_taken = br; IM_stall = im; DM_stall = dm;
      tick();
      quiet();
      repeat (idle) tick();
   endtask

   task automatic set_load_use();
      EXE_memRead = 1'b1; EXE_rd_addr = 5'd5; ID_rs1_addr = 5'd5; ID_rs1_used = 1'b1;
   endtask

   task automatic reset_and_boot();
      rst_n = 1'b0;
      quiet();
      @(negedge clk);
      chk("reset_state", 32'({st_v[1], st_v[0]}), 32'h0);
      chk("reset_wd", 32'(wd_v), 32'h0);
      chk("reset_pc_en", 32'(pc_en_v), 32'h0);
      tick();
      rst_n = 1'b1;
      repeat (4) tick();
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      quiet();
      rst_n  = 1'b0;
      cmp_on = 1'b1;
      repeat (2) tick();
      @(negedge clk);
      chk("rst_outputs_a", 32'({pc_en_v[0], ifid_en_v[0], ifid_flush_v[0], idexe_flush_v[0], pipe_en_v[0]}), 32'h0F);
      chk("rst_state_b", 32'(st_v[1]), 32'h0);
      tick();
      rst_n = 1'b1;

      // boot: four held cycles, then run
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         chk($sformatf("boot_pc_en_c%0d", k), 32'(pc_en_v), 32'h0);
         chk($sformatf("boot_flush_c%0d", k), 32'({ifid_flush_v, idexe_flush_v}), 32'hF);
         chk($sformatf("boot_state_c%0d", k), 32'(st_v[0]), 32'h0);
         tick();
      end
      @(negedge clk);
      chk("boot_done_pc_en", 32'(pc_en_v), 32'h3);
      chk("boot_done_state", 32'(st_v[0]), 32'h1);
      tick();

      // load-use on rs1: one bubble on A, three on B
      set_load_use();
      @(negedge clk);
      chk("lu_pc_en", 32'(pc_en_v), 32'h0);
      chk("lu_ifid_en", 32'(ifid_en_v), 32'h0);
      chk("lu_idexe_flush", 32'(idexe_flush_v), 32'h3);
      tick();
      quiet();
      for (int j = 1; j <= 3; j++) begin
         @(negedge clk);
         chk($sformatf("lu_after_a_%0d", j), 32'(pc_en_v[0]), 32'h1);
         chk($sformatf("lu_after_b_%0d", j), 32'(pc_en_v[1]), (j < 3) ? 32'h0 : 32'h1);
         tick();
      end

      // load to x0 never stalls
      EXE_memRead = 1'b1; EXE_rd_addr = 5'd0; ID_rs1_addr = 5'd0; ID_rs1_used = 1'b1;
      ID_rs2_addr = 5'd0; ID_rs2_used = 1'b1;
      @(negedge clk);
      chk("x0_no_stall", 32'(pc_en_v), 32'h3);
      tick();
      quiet();

      // branch wins over a simultaneous hazard
      set_load_use();
      EXE_branch_taken = 1'b1;
      @(negedge clk);
      chk("br_hz_flushes", 32'({ifid_flush_v, idexe_flush_v}), 32'hF);
      chk("br_hz_pc_en", 32'(pc_en_v), 32'h3);
      tick();
      quiet();
      @(negedge clk);
      chk("br_hz_no_bubble", 32'(pc_en_v), 32'h3);
      chk("br_hz_state_b", 32'(st_v[1]), 32'h1);
      tick();

      // mixed vectors checked by the model
      apply(1'b1, 5'd31, 5'd2, 1'b1, 5'd31, 1'b1, 1'b0, 1'b0, 1'b0, 3);
      apply(1'b1, 5'd9,  5'd9, 1'b0, 5'd9,  1'b0, 1'b0, 1'b0, 1'b0, 1);
      apply(1'b0, 5'd4,  5'd4, 1'b1, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1);
      apply(1'b0, 5'd0,  5'd0, 1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1);
      apply(1'b1, 5'd3,  5'd3, 1'b1, 5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 0);
      apply(1'b1, 5'd3,  5'd3, 1'b1, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 3);
      apply(1'b0, 5'd0,  5'd0, 1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 1'b1, 0);
      apply(1'b1, 5'd12, 5'd1, 1'b1, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0, 3);

      // data-memory freeze parked inside B's bubble
      set_load_use();
      @(negedge clk);
      chk("frzbub_k0_pc_en", 32'(pc_en_v), 32'h0);
      tick();
      quiet();
      DM_stall = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         chk($sformatf("frzbub_en_k%0d", k), 32'({pc_en_v, ifid_en_v, pipe_en_v}), 32'h0);
         chk($sformatf("frzbub_state_k%0d", k), 32'(st_v[1]), 32'h2);
         tick();
      end
      DM_stall = 1'b0;
      for (int k = 11; k <= 12; k++) begin
         @(negedge clk);
         chk($sformatf("frzbub_resume_k%0d", k), 32'({pc_en_v[1], pipe_en_v[1], idexe_flush_v[1]}), 32'h3);
         chk($sformatf("frzbub_a_run_k%0d", k), 32'(pc_en_v[0]), 32'h1);
         tick();
      end
      @(negedge clk);
      chk("frzbub_done_state", 32'(st_v[1]), 32'h1);
      chk("frzbub_done_pc_en", 32'(pc_en_v[1]), 32'h1);
      chk("frzbub_wd", 32'(wd_v), 32'h1);
      tick();

      // asynchronous reset in the middle of a bubble
      set_load_use();
      tick();
      reset_and_boot();

      // watchdog on A: limit 8, 9-cycle instruction stall
      IM_stall = 1'b1;
      for (int k = 1; k <= 9; k++) begin
         @(negedge clk);
         chk($sformatf("wd_rise_k%0d", k), 32'(wd_v[0]), (k >= 9) ? 32'h1 : 32'h0);
         tick();
      end
      IM_stall = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk($sformatf("wd_sticky_%0d", k), 32'(wd_v), 32'h1);
         tick();
      end
      reset_and_boot();

`ifdef HAZARD_PERF_CNT_EN
      // 3 load-use hazards, 2 taken branches, 5 freeze cycles
      for (int h = 0; h < 3; h++) apply(1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3);
      for (int b = 0; b < 2; b++) apply(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1);
      IM_stall = 1'b1;
      repeat (5) tick();
      quiet();
      tick();
      @(negedge clk);
      chk("perf_bubble_a", pb_v[0], 32'd3);
      chk("perf_flush_a",  pf_v[0], 32'd2);
      chk("perf_freeze_a", pz_v[0], 32'd5);
      chk("perf_bubble_b", pb_v[1], 32'd9);
      tick();
      set_load_use();
      tick();
      rst_n = 1'b0;
      quiet();
      @(negedge clk);
      chk("perf_rst_a", pb_v[0] | pf_v[0] | pz_v[0], 32'd0);
      chk("perf_rst_b", pb_v[1] | pf_v[1] | pz_v[1], 32'd0);
      tick();
      rst_n = 1'b1;
      repeat (6) tick();
`endif

      cmp_on = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
